// File: rtl/cmd_pkg.sv
// ============================================================================
// cmd_pkg
// Shared render-command definitions: header field layout, opcodes, and the
// unpacker state encoding. Also imported by command producers.
// Rev 1.0
// ============================================================================
`default_nettype none

package cmd_pkg;

  localparam int HDR_OPC_W  = 4;
  localparam int HDR_NOPS_W = 3;

  // Field MSBs counted down from the word MSB, so the layout holds for any WIDTH >= 16.
  localparam int HDR_OPC_MSB  = 0;
  localparam int HDR_NOPS_MSB = 4;
  localparam int HDR_IMM_MSB  = 7;

  typedef enum logic [3:0] {
    OPC_NOP    = 4'h0,
    OPC_POINT  = 4'h1,
    OPC_LINE   = 4'h2,
    OPC_TRI    = 4'h3,
    OPC_RECT   = 4'h4,
    OPC_BLIT   = 4'h5,
    OPC_SETREG = 4'h6,
    OPC_SYNC   = 4'hF
  } cmd_opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_OUTPUT  = 2'd3
  } unpack_state_t;

endpackage

`default_nettype wire

// File: rtl/command_unpacker.sv
// ============================================================================
// command_unpacker
// Pops header + operand words from a command FIFO and presents each complete
// packet to the renderer over valid/ready. Oversized headers are drained.
// Rev 1.0
// ============================================================================
`default_nettype none

module command_unpacker
  import cmd_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int MAX_OPERANDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              fifo_cmd,
  input  logic                          fifo_empty,
  output logic                          fifo_read,
  output logic                          pkt_valid,
  input  logic                          pkt_ready,
  output logic [HDR_OPC_W-1:0]          pkt_opcode,
  output logic [HDR_NOPS_W-1:0]         pkt_nops,
  output logic [WIDTH-8:0]              pkt_imm,
  output logic [MAX_OPERANDS*WIDTH-1:0] pkt_operands,
  output logic                          err,
  output logic                          busy
);

  localparam logic [HDR_NOPS_W:0] MAX_N = (HDR_NOPS_W+1)'(MAX_OPERANDS);

  unpack_state_t         state, state_next;
  logic [HDR_NOPS_W-1:0] idx;
  logic [HDR_NOPS_W-1:0] remaining;
  logic [HDR_NOPS_W-1:0] hdr_nops;
  logic                  hdr_oversize;

  assign hdr_nops     = fifo_cmd[WIDTH-1-HDR_NOPS_MSB -: HDR_NOPS_W];
  assign hdr_oversize = {1'b0, hdr_nops} > MAX_N;

  // Gated by rst so nothing is popped while reset is held, whatever the state.
  assign fifo_read = rst && (state != ST_OUTPUT) && !fifo_empty;
  assign pkt_valid = (state == ST_OUTPUT);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (fifo_read) begin
          if (hdr_nops == '0) begin
            state_next = ST_OUTPUT;
          end else if (hdr_oversize) begin
            state_next = ST_DRAIN;
          end else begin
            state_next = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (fifo_read && (idx == pkt_nops - 3'd1)) begin
          state_next = ST_OUTPUT;
        end
      end
      ST_DRAIN: begin
        if (fifo_read && (remaining == 3'd1)) begin
          state_next = ST_IDLE;
        end
      end
      ST_OUTPUT: begin
        if (pkt_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_opcode   <= '0;
      pkt_nops     <= '0;
      pkt_imm      <= '0;
      pkt_operands <= '0;
      idx          <= '0;
      remaining    <= '0;
      err          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_read) begin
            pkt_opcode   <= fifo_cmd[WIDTH-1-HDR_OPC_MSB -: HDR_OPC_W];
            pkt_nops     <= hdr_nops;
            pkt_imm      <= fifo_cmd[WIDTH-1-HDR_IMM_MSB:0];
            pkt_operands <= '0;
            idx          <= '0;
            remaining    <= hdr_nops;
            if (hdr_oversize) begin
              err <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (fifo_read) begin
            for (int i = 0; i < MAX_OPERANDS; i++) begin
              if (idx == 3'(i)) begin
                pkt_operands[i*WIDTH +: WIDTH] <= fifo_cmd;
              end
            end
            idx <= idx + 3'd1;
          end
        end
        ST_DRAIN: begin
          if (fifo_read) begin
            remaining <= remaining - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_command_unpacker.sv
// ============================================================================
// tb_command_unpacker
// Self-checking bench: directed vector table, hand-written corner sequences,
// and a randomized packet stream checked against a packet-level model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_command_unpacker;

  localparam int WIDTH = 16;
  localparam int MAXOP = 4;
  localparam int OPW   = MAXOP * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] fifo_cmd = '0;
  logic             fifo_empty = 1'b1;
  logic             fifo_read;
  logic             pkt_valid;
  logic             pkt_ready = 1'b0;
  logic [3:0]       pkt_opcode;
  logic [2:0]       pkt_nops;
  logic [8:0]       pkt_imm;
  logic [OPW-1:0]   pkt_operands;
  logic             err;
  logic             busy;

  command_unpacker #(.WIDTH(WIDTH), .MAX_OPERANDS(MAXOP)) dut (
    .clk(clk), .rst(rst),
    .fifo_cmd(fifo_cmd), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_opcode(pkt_opcode), .pkt_nops(pkt_nops), .pkt_imm(pkt_imm),
    .pkt_operands(pkt_operands), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [WIDTH-1:0] q[$];
  logic             hold = 1'b0;

  task automatic refresh();
    fifo_empty = hold || (q.size() == 0);
    fifo_cmd   = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    q.push_back(w);
    refresh();
  endtask

  // Head advances after the edge that sampled a pop; the #1 keeps the DUT's view race-free.
  always @(posedge clk) begin
    if (fifo_read && !fifo_empty) begin
      #1;
      void'(q.pop_front());
      refresh();
    end
  end

  function automatic logic [79:0] pkt();
    return {pkt_opcode, pkt_nops, pkt_imm, pkt_operands};
  endfunction

  task automatic wait_valid(input string name, input int exp_lat);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!pkt_valid && cyc < 100);
    check({name, "_lat"}, 96'(cyc), 96'(exp_lat));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [191:0] words;   // word k at [k*16 +: 16], first popped in the low bits
    int           n;
    logic [3:0]   opc;
    logic [2:0]   nops;
    logic [8:0]   imm;
    logic [63:0]  ops;
    logic         err;
  } vec_t;

  vec_t vt[8];

  // ---------------- random phase ----------------
  logic [79:0] exp_q[$];
  logic        rnd_on = 1'b0;
  int          got = 0;

  always @(negedge clk) begin
    if (rnd_on) begin
      hold      = ($urandom_range(0, 3) == 0);
      pkt_ready = ($urandom_range(0, 2) != 0);
      refresh();
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_pkt", 96'(pkt()), 96'd0);
        end else begin
          check("rnd_pkt", 96'(pkt()), 96'(exp_q[0]));
          void'(exp_q.pop_front());
          got++;
        end
      end
    end
  end

  initial begin
    logic [3:0]  r_opc;
    logic [2:0]  r_nops;
    logic [8:0]  r_imm;
    logic [15:0] r_w;
    logic [63:0] r_ops;
    logic        exp_err;
    int          n_exp;
    int          cyc;

    vt[0] = '{words: 192'h1005, n: 1, opc: 4'h1, nops: 3'd0, imm: 9'h005, ops: 64'h0, err: 1'b0};
    vt[1] = '{words: 192'hBBBB_AAAA_2400, n: 3, opc: 4'h2, nops: 3'd2, imm: 9'h000,
              ops: 64'h0000_0000_BBBB_AAAA, err: 1'b0};
    vt[2] = '{words: 192'h4444_3333_2222_1111_4801, n: 5, opc: 4'h4, nops: 3'd4, imm: 9'h001,
              ops: 64'h4444_3333_2222_1111, err: 1'b0};
    vt[3] = '{words: 192'h1234_5200, n: 2, opc: 4'h5, nops: 3'd1, imm: 9'h000,
              ops: 64'h0000_0000_0000_1234, err: 1'b0};
    vt[4] = '{words: 192'h61FF, n: 1, opc: 4'h6, nops: 3'd0, imm: 9'h1FF, ops: 64'h0, err: 1'b0};
    vt[5] = '{words: 192'h1005_0006_0005_0004_0003_0002_0001_3C00, n: 8,
              opc: 4'h1, nops: 3'd0, imm: 9'h005, ops: 64'h0, err: 1'b1};
    vt[6] = '{words: 192'hDEAD_F3FF, n: 2, opc: 4'hF, nops: 3'd1, imm: 9'h1FF,
              ops: 64'h0000_0000_0000_DEAD, err: 1'b1};
    vt[7] = '{words: 192'h0003_0002_0001_8600_00A7_00A6_00A5_00A4_00A3_00A2_00A1_7E00, n: 12,
              opc: 4'h8, nops: 3'd3, imm: 9'h000, ops: 64'h0000_0003_0002_0001, err: 1'b1};

    // ---- reset state, with a word waiting in the FIFO ----
    push(16'h1005);
    repeat (3) @(negedge clk);
    check("rst_fifo_read", 96'(fifo_read), 96'd0);
    check("rst_pkt_valid", 96'(pkt_valid), 96'd0);
    check("rst_fields", 96'(pkt()), 96'd0);
    check("rst_err_busy", 96'({err, busy}), 96'd0);
    q.delete();
    refresh();
    rst = 1'b1;
    @(negedge clk);

    // ---- table-driven packets ----
    for (int i = 0; i < 8; i++) begin
      pkt_ready = 1'b1;
      for (int k = 0; k < vt[i].n; k++) push(vt[i].words[k*16 +: 16]);
      wait_valid($sformatf("vec%0d", i), vt[i].n);
      check($sformatf("vec%0d_opc", i), 96'(pkt_opcode), 96'(vt[i].opc));
      check($sformatf("vec%0d_nops", i), 96'(pkt_nops), 96'(vt[i].nops));
      check($sformatf("vec%0d_imm", i), 96'(pkt_imm), 96'(vt[i].imm));
      check($sformatf("vec%0d_ops", i), 96'(pkt_operands), 96'(vt[i].ops));
      check($sformatf("vec%0d_err", i), 96'(err), 96'(vt[i].err));
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), 96'({pkt_valid, busy}), 96'd0);
    end

    // ---- backpressure: 5 stalled cycles with more words queued ----
    pkt_ready = 1'b0;
    push(16'h2400); push(16'hAAAA); push(16'hBBBB); push(16'h1005);
    wait_valid("bp", 3);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_stable%0d", c), 96'({pkt_valid, pkt()}),
            96'({1'b1, 4'h2, 3'd2, 9'h000, 64'h0000_0000_BBBB_AAAA}));
      check($sformatf("bp_no_read%0d", c), 96'(fifo_read), 96'd0);
      @(negedge clk);
    end
    pkt_ready = 1'b1;
    check("bp_accept_no_read", 96'(fifo_read), 96'd0);
    @(negedge clk);
    check("bp_bubble", 96'({pkt_valid, fifo_read}), 96'b01);
    @(negedge clk);
    check("bp_next_pkt", 96'({pkt_valid, pkt()}), 96'({1'b1, 4'h1, 3'd0, 9'h005, 64'h0}));
    @(negedge clk);

    // ---- underflow gap between operands ----
    push(16'h2400); push(16'hAAAA);
    repeat (2) @(negedge clk);
    hold = 1'b1;
    push(16'hBBBB);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("gap_hold%0d", c), 96'({fifo_read, pkt_valid, busy}), 96'b001);
      @(negedge clk);
    end
    hold = 1'b0;
    refresh();
    wait_valid("gap", 1);
    check("gap_pkt", 96'(pkt()), 96'({4'h2, 3'd2, 9'h000, 64'h0000_0000_BBBB_AAAA}));
    @(negedge clk);

    // ---- reset in COLLECT after one of two operands ----
    push(16'h2400); push(16'hAAAA);
    repeat (2) @(negedge clk);
    check("mid_busy", 96'(busy), 96'd1);
    rst = 1'b0;
    push(16'hBBBB);
    check("mid_rst_no_read", 96'(fifo_read), 96'd0);
    @(negedge clk);
    check("mid_rst_outputs", 96'({fifo_read, pkt_valid, err, busy}), 96'd0);
    check("mid_rst_fields", 96'(pkt()), 96'd0);
    q.delete();
    refresh();
    rst = 1'b1;
    push(16'h1005);
    wait_valid("post_rst", 1);
    check("post_rst_pkt", 96'({err, pkt()}), 96'({1'b0, 4'h1, 3'd0, 9'h005, 64'h0}));
    @(negedge clk);

    // ---- randomized stream vs. packet-level model ----
    exp_err = 1'b0;
    n_exp   = 0;
    for (int p = 0; p < 40; p++) begin
      r_opc  = 4'($urandom_range(0, 15));
      r_nops = (p == 5) ? 3'd6 : 3'($urandom_range(0, 7));
      r_imm  = 9'($urandom_range(0, 511));
      push({r_opc, r_nops, r_imm});
      r_ops = '0;
      for (int k = 0; k < int'(r_nops); k++) begin
        r_w = 16'($urandom);
        push(r_w);
        if (int'(r_nops) <= MAXOP) r_ops[k*16 +: 16] = r_w;
      end
      if (int'(r_nops) > MAXOP) begin
        exp_err = 1'b1;
      end else begin
        exp_q.push_back({r_opc, r_nops, r_imm, r_ops});
        n_exp++;
      end
    end
    rnd_on = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || exp_q.size() != 0 || pkt_valid) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    rnd_on = 1'b0;
    @(negedge clk);
    hold = 1'b0;
    pkt_ready = 1'b1;
    refresh();
    check("rnd_done_in_time", 96'(cyc < 5000), 96'd1);
    check("rnd_pkt_count", 96'(got), 96'(n_exp));
    check("rnd_err", 96'(err), 96'(exp_err));
    check("rnd_idle", 96'(busy), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
